pll_lock_monitor: RTL and testbench
===================================

Name: pll_lock_monitor

Overview:
- Digital reader for the on-chip mixed-signal PLL. Counts rising edges of the pre-divided PLL feedback clock over a programmable window of reference `clk` cycles.
- Compares each window's count with a target and tolerance, then asserts `locked` after N consecutive good windows.
- Sits in the digital half of the PLL tile, between the analog feedback-divider output and the `uo_out` status pins.

Parameters:
- WIN_W, 12, width of window-length counter (window up to 2^WIN_W-1 clk cycles)
- CNT_W, 10, width of edge counter / target; count saturates at 2^CNT_W-1
- TOL_W, 4, width of tolerance input
- LOCKN_W, 3, width of consecutive-good-window requirement

Ports:
- clk  in  1  reference clock (PLL reference)
- rst_n  in  1  asynchronous active-low reset
- ena  in  1  monitor enable; low forces IDLE
- fb_async  in  1  divided PLL feedback, asynchronous to clk, must be < clk/2
- win_len  in  WIN_W  window length in clk cycles, sampled at window start
- target  in  CNT_W  expected edge count per window
- tol  in  TOL_W  allowed |count-target|
- lock_n  in  LOCKN_W  good windows required for lock (0 treated as 1)
- count_out  out  CNT_W  last completed window count
- count_valid  out  1  one-cycle pulse when count_out updates
- locked  out  1  lock indication
- lost_lock  out  1  one-cycle pulse on locked 1->0 due to a bad window

Behaviour:
- Reset values: count_out=0, count_valid=0, locked=0, lost_lock=0, FSM=IDLE, all counters 0.
- fb_async passes through a 2-FF synchronizer plus a third delay flop. A rising edge is detected as sync=1 and delayed=0. Edge-to-count latency is 3 clk.
- FSM states:
  - IDLE:
    - Enters MEASURE when ena=1 and win_len!=0.
    - Latches win_len into the window down-counter as win_len-1.
    - Clears the edge counter.
  - MEASURE:
    - Each detected edge increments the edge counter, saturating at all-ones.
    - The window counter decrements every cycle.
    - Goes to EVAL on the cycle where the window counter is 0, after counting any edge in that cycle. MEASURE therefore lasts exactly win_len cycles.
  - EVAL:
    - Lasts one cycle. Edges detected in this cycle are dropped.
    - Computes diff = |count - target| at CNT_W+1 bits with no wrap. good = (diff <= tol).
    - Registers count_out and pulses count_valid in the next cycle.
    - If good: good_cnt increments, saturating at max(lock_n,1). locked sets when good_cnt reaches max(lock_n,1), visible in the same cycle as count_valid.
    - If bad: good_cnt=0 and locked=0. lost_lock pulses if locked was 1.
    - Then returns to MEASURE with win_len re-sampled, or to IDLE if ena=0 or win_len=0.
- Measurement period is win_len+1 clk cycles.
- ena=0 in any state: next cycle goes to IDLE, and good_cnt, locked and the edge counter clear. No lost_lock pulse. count_out holds its value. A partial window is discarded with no count_valid.
- win_len, target, tol and lock_n may change at any time:
  - target, tol and lock_n take effect at the next EVAL.
  - win_len takes effect at the next window start.
- Lowering lock_n below good_cnt while locked keeps locked=1.
- Async reset mid-window returns everything to reset values immediately. The synchronizer flops also reset to 0.

Optional Feature:
- Macro LOCK_MON_HYST_EN.
- Defined: while locked=1, the unlock test uses tolerance tol*2, computed at TOL_W+1 bits. Acquisition still uses tol.
- Undefined: tol is used for both acquisition and unlock; no extra logic.

Decomposition:
- Package pll_mon_pkg holds:
  - FSM state enum (IDLE, MEASURE, EVAL)
  - default width localparams
  - a function abs_diff(count, target) returning CNT_W+1 bits
- One sub-module, edge_sync, handles the 2-FF synchronizer and rising-edge detect. It has its own async active-low reset.

Test Plan:
1. Reset, then ena=1, win_len=64, fb period 8 clk (4 high/4 low), target=8, tol=0, lock_n=3:
   - count_valid every 65 cycles with count_out=8.
   - locked rises at the 3rd count_valid.
2. Locked as in 1, then fb period switched to 4:
   - The next full window gives count_out=16.
   - locked falls with a single-cycle lost_lock pulse.
   - Relock requires 3 further windows with target changed to 16.
3. CNT_W=4 override, fb period 2, win_len=64:
   - count_out=15 (saturated).
   - With target=15, tol=0: good, with no wrap to 0.
4. Mid-window ena drop at cycle 30 of a 64-cycle window while locked:
   - IDLE next cycle, locked=0, no lost_lock, no count_valid, count_out unchanged.
   - Re-enable: the first window starts cleanly.
5. rst_n asserted mid-MEASURE:
   - All outputs 0 asynchronously (checked before the next clk edge).
   - After release, win_len=0 keeps the block in IDLE with no count_valid.
6. LOCK_MON_HYST_EN defined, target=8, tol=1, locked:
   - count 10 (diff 2) keeps locked.
   - count 11 drops lock.
   - Undefined build: count 10 drops lock.

Source files
------------

// File: rtl/pll_mon_pkg.sv
// Shared types, default widths and helpers for the PLL lock monitor.
package pll_mon_pkg;

   localparam int unsigned WIN_W_DEF   = 12;
   localparam int unsigned CNT_W_DEF   = 10;
   localparam int unsigned TOL_W_DEF   = 4;
   localparam int unsigned LOCKN_W_DEF = 3;

   // Wide enough for any counter width in use; callers keep the low CNT_W+1 bits.
   localparam int unsigned DIFF_W_MAX  = 32;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      MEASURE = 2'd1,
      EVAL    = 2'd2
   } state_t;

   // |count - target| without wrap-around.
   function automatic logic [DIFF_W_MAX-1:0] abs_diff(input logic [DIFF_W_MAX-1:0] count,
                                                      input logic [DIFF_W_MAX-1:0] target);
      return (count >= target) ? (count - target) : (target - count);
   endfunction

endpackage

// File: rtl/pll_lock_monitor_edge_sync.sv
// Two-flop synchronizer plus delay flop for the divided PLL feedback; flags rising edges.
module edge_sync (
   input  logic clk,
   input  logic rst_n,
   input  logic fb_async,
   output logic rise_c
);

   logic sync1;
   logic sync2;
   logic dly;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1 <= 1'b0;
         sync2 <= 1'b0;
         dly   <= 1'b0;
      end else begin
         sync1 <= fb_async;
         sync2 <= sync1;
         dly   <= sync2;
      end
   end

   assign rise_c = sync2 & ~dly;

endmodule

// File: rtl/pll_lock_monitor.sv
// Counts PLL feedback edges per reference window and declares lock after N good windows.
// Optional macro LOCK_MON_HYST_EN: widen the unlock tolerance to 2*tol while locked.
module pll_lock_monitor
   import pll_mon_pkg::*;
#(
   parameter int unsigned WIN_W   = WIN_W_DEF,
   parameter int unsigned CNT_W   = CNT_W_DEF,
   parameter int unsigned TOL_W   = TOL_W_DEF,
   parameter int unsigned LOCKN_W = LOCKN_W_DEF
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               ena,
   input  logic               fb_async,
   input  logic [WIN_W-1:0]   win_len,
   input  logic [CNT_W-1:0]   target,
   input  logic [TOL_W-1:0]   tol,
   input  logic [LOCKN_W-1:0] lock_n,
   output logic [CNT_W-1:0]   count_out,
   output logic               count_valid,
   output logic               locked,
   output logic               lost_lock
);

   localparam int unsigned DIFF_W = CNT_W + 1;
   localparam int unsigned LCK_W  = LOCKN_W + 1;

   state_t               state, state_n;
   logic [WIN_W-1:0]     win_cnt, win_cnt_n;
   logic [CNT_W-1:0]     edge_cnt, edge_cnt_n;
   logic [CNT_W-1:0]     count_out_n;
   logic [LOCKN_W-1:0]   good_cnt, good_cnt_n;
   logic                 count_valid_n;
   logic                 locked_n;
   logic                 lost_lock_n;

   logic                 rise_c;
   logic                 start_c;
   logic                 good_c;
   logic [DIFF_W-1:0]    diff_c;
   logic [TOL_W:0]       tol_eff_c;
   logic [LOCKN_W-1:0]   lock_req_c;

   edge_sync u_edge_sync (
      .clk      (clk),
      .rst_n    (rst_n),
      .fb_async (fb_async),
      .rise_c   (rise_c)
   );

   assign start_c    = ena && (win_len != '0);
   assign lock_req_c = (lock_n == '0) ? LOCKN_W'(1) : lock_n;
   assign diff_c     = DIFF_W'(abs_diff(DIFF_W_MAX'(edge_cnt), DIFF_W_MAX'(target)));

`ifdef LOCK_MON_HYST_EN
   // Once locked, only a larger excursion counts as a bad window.
   assign tol_eff_c  = locked ? {tol, 1'b0} : {1'b0, tol};
`else
   assign tol_eff_c  = {1'b0, tol};
`endif

   assign good_c     = (DIFF_W_MAX'(diff_c) <= DIFF_W_MAX'(tol_eff_c));

   // Next-state and registered-output logic.
   always_comb begin
      state_n       = state;
      win_cnt_n     = win_cnt;
      edge_cnt_n    = edge_cnt;
      good_cnt_n    = good_cnt;
      count_out_n   = count_out;
      count_valid_n = 1'b0;
      locked_n      = locked;
      lost_lock_n   = 1'b0;

      if (!ena) begin
         state_n    = IDLE;
         edge_cnt_n = '0;
         good_cnt_n = '0;
         locked_n   = 1'b0;
      end else begin
         case (state)
            IDLE: begin
               edge_cnt_n = '0;
               if (start_c) begin
                  state_n   = MEASURE;
                  win_cnt_n = win_len - WIN_W'(1);
               end
            end

            MEASURE: begin
               if (rise_c && (edge_cnt != '1)) begin
                  edge_cnt_n = edge_cnt + CNT_W'(1);
               end
               if (win_cnt == '0) begin
                  state_n = EVAL;
               end else begin
                  win_cnt_n = win_cnt - WIN_W'(1);
               end
            end

            EVAL: begin
               count_out_n   = edge_cnt;
               count_valid_n = 1'b1;
               if (good_c) begin
                  // A lowered lock_n never pulls good_cnt down or drops lock.
                  if ((LCK_W'(good_cnt) + LCK_W'(1)) >= LCK_W'(lock_req_c)) begin
                     good_cnt_n = (good_cnt > lock_req_c) ? good_cnt : lock_req_c;
                     locked_n   = 1'b1;
                  end else begin
                     good_cnt_n = good_cnt + LOCKN_W'(1);
                  end
               end else begin
                  good_cnt_n  = '0;
                  locked_n    = 1'b0;
                  lost_lock_n = locked;
               end
               edge_cnt_n = '0;
               if (start_c) begin
                  state_n   = MEASURE;
                  win_cnt_n = win_len - WIN_W'(1);
               end else begin
                  state_n = IDLE;
               end
            end

            default: begin
               state_n = IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         win_cnt     <= '0;
         edge_cnt    <= '0;
         good_cnt    <= '0;
         count_out   <= '0;
         count_valid <= 1'b0;
         locked      <= 1'b0;
         lost_lock   <= 1'b0;
      end else begin
         state       <= state_n;
         win_cnt     <= win_cnt_n;
         edge_cnt    <= edge_cnt_n;
         good_cnt    <= good_cnt_n;
         count_out   <= count_out_n;
         count_valid <= count_valid_n;
         locked      <= locked_n;
         lost_lock   <= lost_lock_n;
      end
   end

endmodule

// File: tb/tb_pll_lock_monitor.sv
// Self-checking bench for pll_lock_monitor: directed window table, corner sequences, random windows.
module tb_pll_lock_monitor;

   localparam int unsigned WIN_W   = 12;
   localparam int unsigned CNT_W   = 10;
   localparam int unsigned TOL_W   = 4;
   localparam int unsigned LOCKN_W = 3;
   localparam int          HIST    = 16384;
`ifdef LOCK_MON_HYST_EN
   localparam bit HYST = 1'b1;
`else
   localparam bit HYST = 1'b0;
`endif

   logic               clk = 1'b0;
   logic               rst_n;
   logic               ena;
   logic               fb_async = 1'b0;
   logic [WIN_W-1:0]   win_len;
   logic [CNT_W-1:0]   target;
   logic [3:0]         target4;
   logic [TOL_W-1:0]   tol;
   logic [LOCKN_W-1:0] lock_n;
   logic [CNT_W-1:0]   count_out;
   logic               count_valid, locked, lost_lock;
   logic [3:0]         count_out4;
   logic               count_valid4, locked4, lost_lock4;

   pll_lock_monitor dut (
      .clk(clk), .rst_n(rst_n), .ena(ena), .fb_async(fb_async), .win_len(win_len),
      .target(target), .tol(tol), .lock_n(lock_n), .count_out(count_out),
      .count_valid(count_valid), .locked(locked), .lost_lock(lost_lock)
   );

   pll_lock_monitor #(.CNT_W(4)) dut4 (
      .clk(clk), .rst_n(rst_n), .ena(ena), .fb_async(fb_async), .win_len(win_len),
      .target(target4), .tol(tol), .lock_n(lock_n), .count_out(count_out4),
      .count_valid(count_valid4), .locked(locked4), .lost_lock(lost_lock4)
   );

   always #5 clk = ~clk;

   // Feedback generator: fixed half period, or random level lengths of 1..6 clk.
   int fb_half = 4;
   bit fb_rand = 1'b0;
   int fb_left = 0;
   always @(negedge clk) begin
      if (fb_left <= 1) begin
         fb_async = ~fb_async;
         fb_left  = fb_rand ? int'($urandom_range(6, 1)) : fb_half;
      end else begin
         fb_left--;
      end
   end

   // History of the feedback level seen at every rising clk edge.
   int   cyc = 0;
   logic s_hist [0:HIST-1];
   always @(posedge clk) begin
      if (cyc < HIST) s_hist[cyc] = fb_async;
      cyc++;
   end

   int checks = 0;
   int errors = 0;
   int rst_cyc = 0;
   int e0 = 0;
   int cur_wl = 0;
   int m_streak = 0;
   bit m_locked = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d, want %0d", name, act, exp);
      end
   endtask

   function automatic bit s_at(input int j);
      if (j < rst_cyc || j < 0 || j >= HIST) return 1'b0;
      return bit'(s_hist[j]);
   endfunction

   // Rising transitions seen by a window that enters measurement at edge 'start'.
   function automatic int model_count(input int start, input int wl, input int cmax);
      int n = 0;
      for (int j = start - 2; j <= start + wl - 3; j++) begin
         if (!s_at(j) && s_at(j + 1)) n++;
      end
      return (n > cmax) ? cmax : n;
   endfunction

   // Wait for the current window's result, update the lock model and compare (-1 = use model).
   task automatic finish_window(input string tag, input int exp_cnt, input int exp_lk,
                                input int exp_lost);
      int end_cyc = e0 + cur_wl + 1;
      int mcnt, lreq, tol_eff, diff;
      bit mlost;
      do begin
         @(negedge clk);
         if (cyc - 1 < end_cyc) begin
            chk({tag, "_cv_quiet"}, {31'd0, count_valid}, 32'd0);
         end
      end while (cyc - 1 < end_cyc);
      mcnt    = model_count(e0, cur_wl, (1 << CNT_W) - 1);
      lreq    = (lock_n == '0) ? 1 : int'(lock_n);
      tol_eff = (HYST && m_locked) ? 2 * int'(tol) : int'(tol);
      diff    = mcnt - int'(target);
      if (diff < 0) diff = -diff;
      if (diff <= tol_eff) begin
         m_streak++;
         if (m_streak >= lreq) m_locked = 1'b1;
         mlost = 1'b0;
      end else begin
         mlost    = m_locked;
         m_locked = 1'b0;
         m_streak = 0;
      end
      chk({tag, "_cv"}, {31'd0, count_valid}, 32'd1);
      chk({tag, "_count"}, 32'(count_out), (exp_cnt >= 0) ? exp_cnt : mcnt);
      chk({tag, "_locked"}, {31'd0, locked}, (exp_lk >= 0) ? exp_lk : int'(m_locked));
      chk({tag, "_lost"}, {31'd0, lost_lock}, (exp_lost >= 0) ? exp_lost : int'(mlost));
      e0     = end_cyc;
      cur_wl = int'(win_len);
   endtask

   typedef struct {
      int half;
      int wl_next;
      int tgt;
      int tl;
      int lkn;
      int ecnt;
      int elk;
      int elost;
   } vec_t;

   vec_t tbl [12];

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
      $fatal(1);
   end

   initial begin
      // Windows 0-7: acquire at period 8, lose on switch to period 4, relock at target 16.
      tbl[0]  = '{4, 64,  8, 0, 3,  8, 0, 0};
      tbl[1]  = '{4, 64,  8, 0, 3,  8, 0, 0};
      tbl[2]  = '{4, 64,  8, 0, 3,  8, 1, 0};
      tbl[3]  = '{4, 64,  8, 0, 3,  8, 1, 0};
      tbl[4]  = '{2, 64,  8, 0, 3, -1, 0, 1};
      tbl[5]  = '{2, 64, 16, 0, 3, 16, 0, 0};
      tbl[6]  = '{2, 64, 16, 0, 3, 16, 0, 0};
      tbl[7]  = '{2, 64, 16, 0, 3, 16, 1, 0};
      // Windows 8-11: tolerance hysteresis at period 4 with windows of 32, 32, 40, 44.
      tbl[8]  = '{2, 32,  8, 1, 1,  8, 1, 0};
      tbl[9]  = '{2, 40,  8, 1, 1,  8, 1, 0};
      tbl[10] = '{2, 44,  8, 1, 1, 10, HYST ? 1 : 0, HYST ? 0 : 1};
      tbl[11] = '{2, 32,  8, 1, 1, 11, 0, HYST ? 1 : 0};

      rst_n = 1'b0; ena = 1'b0; win_len = 12'd64; target = 10'd8; target4 = 4'd0;
      tol = 4'd0; lock_n = 3'd3;
      repeat (3) @(negedge clk);
      chk("rst_count", 32'(count_out), 32'd0);
      chk("rst_cv", {31'd0, count_valid}, 32'd0);
      chk("rst_locked", {31'd0, locked}, 32'd0);
      chk("rst_lost", {31'd0, lost_lock}, 32'd0);
      chk("rst_count4", 32'(count_out4), 32'd0);
      rst_n = 1'b1;
      rst_cyc = cyc;
      repeat (3) begin
         @(negedge clk);
         chk("disabled_cv", {31'd0, count_valid}, 32'd0);
      end

      ena = 1'b1;
      e0 = cyc;
      cur_wl = int'(win_len);
      for (int i = 0; i < 8; i++) begin
         fb_half = tbl[i].half;
         win_len = WIN_W'(tbl[i].wl_next);
         target  = CNT_W'(tbl[i].tgt);
         tol     = TOL_W'(tbl[i].tl);
         lock_n  = LOCKN_W'(tbl[i].lkn);
         finish_window($sformatf("row%0d", i), tbl[i].ecnt, tbl[i].elk, tbl[i].elost);
      end

      // Drop enable 30 cycles into a locked window.
      chk("t4_pre_locked", {31'd0, locked}, 32'd1);
      while (cyc - 1 < e0 + 29) @(negedge clk);
      ena = 1'b0;
      @(negedge clk);
      chk("t4_locked", {31'd0, locked}, 32'd0);
      chk("t4_lost", {31'd0, lost_lock}, 32'd0);
      chk("t4_cv", {31'd0, count_valid}, 32'd0);
      chk("t4_count_hold", 32'(count_out), 32'd16);
      m_locked = 1'b0;
      m_streak = 0;
      repeat (5) begin
         @(negedge clk);
         chk("t4_idle_cv", {31'd0, count_valid}, 32'd0);
      end
      ena = 1'b1;
      e0 = cyc;
      cur_wl = int'(win_len);
      finish_window("t4_reen", 16, 0, 0);

      // Saturation in the 4-bit instance at period 2.
      fb_half = 1; target = 10'd32; target4 = 4'd15; tol = 4'd0; lock_n = 3'd1;
      finish_window("t3_settle", -1, -1, -1);
      finish_window("t3_full", 32, 1, 0);
      chk("t3_cv4", {31'd0, count_valid4}, 32'd1);
      chk("t3_count4", 32'(count_out4), 32'd15);
      chk("t3_locked4", {31'd0, locked4}, 32'd1);
      chk("t3_lost4", {31'd0, lost_lock4}, 32'd0);

      // Asynchronous reset in the middle of a measurement.
      fb_half = 2;
      repeat (20) @(negedge clk);
      chk("t5_pre_locked", {31'd0, locked}, 32'd1);
      #2 rst_n = 1'b0;
      #1;
      chk("t5_count", 32'(count_out), 32'd0);
      chk("t5_cv", {31'd0, count_valid}, 32'd0);
      chk("t5_locked", {31'd0, locked}, 32'd0);
      chk("t5_lost", {31'd0, lost_lock}, 32'd0);
      chk("t5_count4", 32'(count_out4), 32'd0);
      chk("t5_locked4", {31'd0, locked4}, 32'd0);
      win_len = 12'd0;
      ena = 1'b1;
      @(negedge clk);
      rst_n = 1'b1;
      rst_cyc = cyc;
      m_locked = 1'b0;
      m_streak = 0;
      repeat (100) begin
         @(negedge clk);
         chk("t5_zero_len_cv", {31'd0, count_valid}, 32'd0);
      end

      win_len = 12'd32;
      e0 = cyc;
      cur_wl = 32;
      for (int i = 8; i < 12; i++) begin
         fb_half = tbl[i].half;
         win_len = WIN_W'(tbl[i].wl_next);
         target  = CNT_W'(tbl[i].tgt);
         tol     = TOL_W'(tbl[i].tl);
         lock_n  = LOCKN_W'(tbl[i].lkn);
         finish_window($sformatf("row%0d", i), tbl[i].ecnt, tbl[i].elk, tbl[i].elost);
      end

      // Random feedback and random per-window settings against the model.
      fb_rand = 1'b1;
      for (int k = 0; k < 40; k++) begin
         target  = CNT_W'($urandom_range(30, 0));
         tol     = TOL_W'($urandom_range(15, 0));
         lock_n  = LOCKN_W'($urandom_range(4, 0));
         win_len = WIN_W'($urandom_range(80, 8));
         finish_window($sformatf("rnd%0d", k), -1, -1, -1);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
